// File: rtl/seven_seg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : seven_seg_pkg
// Purpose  : Shared stopwatch display/formatter package. Holds the ASCII
//            constants used on the UART path, the formatter FSM state type,
//            the binary-to-BCD converter and the digit-to-ASCII helper.
// Ports    : none (package)
// Revision : 1.1 - ASCII constants, fmt_state_t and digit_to_ascii added
//==============================================================================
package seven_seg_pkg;

   localparam logic [7:0] ASC_ZERO  = 8'h30;
   localparam logic [7:0] ASC_DOT   = 8'h2E;
   localparam logic [7:0] ASC_COLON = 8'h3A;
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_LF    = 8'h0A;

   typedef enum logic [2:0] {
      FMT_IDLE      = 3'd0,
      FMT_LOAD      = 3'd1,
      FMT_SEND      = 3'd2,
      FMT_WAIT_ACK  = 3'd3,
      FMT_WAIT_DONE = 3'd4,
      FMT_NEXT      = 3'd5
   } fmt_state_t;

   // Shift-and-add-3 conversion. Result is {hundreds, tens, ones}; an 8-bit
   // input never exceeds 255, so the hundreds digit never needs correction.
   function automatic logic [11:0] hex8_to_bcd_opt(input logic [7:0] bin);
      logic [19:0] sr;
      sr = {12'd0, bin};
      for (int i = 0; i < 8; i++) begin
         if (sr[11:8] >= 4'd5)
            sr[11:8] = sr[11:8] + 4'd3;
         if (sr[15:12] >= 4'd5)
            sr[15:12] = sr[15:12] + 4'd3;
         sr = sr << 1;
      end
      return sr[19:8];
   endfunction

   function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
      return ASC_ZERO + {4'd0, d};
   endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_uart_fmt.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : stopwatch_uart_fmt
// Purpose  : On trig, snapshots the stopwatch counters, converts them to
//            decimal ASCII and streams "SS.CC\r\n" byte by byte into uart_tx
//            over its start/busy handshake. Values above 99 show as 99.
//            Build macro STOPWATCH_UART_FMT_MIN_EN prefixes the frame with
//            "M:" taken from min_bin (9-byte frame instead of 7).
// Ports    : clk      - system clock
//            rst      - synchronous reset, active-high
//            trig     - single-cycle report request
//            sec_bin  - seconds count (binary)
//            csec_bin - centiseconds count (binary)
//            min_bin  - minutes count (only with STOPWATCH_UART_FMT_MIN_EN)
//            tx_busy  - busy flag from uart_tx
//            tx_data  - byte presented to uart_tx
//            tx_start - one-cycle start strobe to uart_tx
//            busy     - frame in progress
//            drop     - one-cycle pulse when a trig was ignored
// Revision : 1.0 - initial release
//==============================================================================
module stopwatch_uart_fmt
   import seven_seg_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trig,
   input  logic [7:0] sec_bin,
   input  logic [6:0] csec_bin,
   input  logic [1:0] min_bin,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic       busy,
   output logic       drop
);

   localparam int FRAME_LEN = 7;
`ifdef STOPWATCH_UART_FMT_MIN_EN
   localparam int c_NUM_BYTES = FRAME_LEN + 2;
`else
   localparam int c_NUM_BYTES = FRAME_LEN;
`endif
   localparam logic [3:0] c_LAST_IDX = 4'(c_NUM_BYTES - 1);
   localparam int c_CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [c_CNT_W-1:0] c_ACK_LAST = c_CNT_W'(ACK_TIMEOUT - 1);

   fmt_state_t         r_state, w_state_nxt;
   logic [3:0]         r_idx;
   logic [c_CNT_W-1:0] r_ack_cnt;
   logic [7:0]         r_sec_snap;
   logic [6:0]         r_csec_snap;
   logic [3:0]         r_sec_t, r_sec_o, r_csec_t, r_csec_o;
   logic [7:0]         r_tx_data;
   logic               r_tx_start;
   logic               r_drop;
   logic [11:0]        w_sec_bcd, w_csec_bcd;
   logic [7:0]         w_byte;

`ifdef STOPWATCH_UART_FMT_MIN_EN
   logic [1:0]         r_min_snap;
   logic [3:0]         r_min_d;
`else
   logic               w_unused;
   assign w_unused = ^min_bin;
`endif

   // A non-zero hundreds digit means the value is above 99; showing 9/9 in
   // that case is the same as clamping the binary value to 99 first.
   assign w_sec_bcd  = hex8_to_bcd_opt(r_sec_snap);
   assign w_csec_bcd = hex8_to_bcd_opt({1'b0, r_csec_snap});

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= FMT_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FMT_IDLE:      if (trig) w_state_nxt = FMT_LOAD;
         FMT_LOAD:      w_state_nxt = FMT_SEND;
         FMT_SEND:      w_state_nxt = FMT_WAIT_ACK;
         FMT_WAIT_ACK:  if (tx_busy || (r_ack_cnt == c_ACK_LAST))
                           w_state_nxt = FMT_WAIT_DONE;
         FMT_WAIT_DONE: if (!tx_busy) w_state_nxt = FMT_NEXT;
         FMT_NEXT:      w_state_nxt = (r_idx == c_LAST_IDX) ? FMT_IDLE : FMT_SEND;
         default:       w_state_nxt = FMT_IDLE;
      endcase
   end

   always_comb begin
      w_byte = 8'h00;
`ifdef STOPWATCH_UART_FMT_MIN_EN
      case (r_idx)
         4'd0:    w_byte = digit_to_ascii(r_min_d);
         4'd1:    w_byte = ASC_COLON;
         4'd2:    w_byte = digit_to_ascii(r_sec_t);
         4'd3:    w_byte = digit_to_ascii(r_sec_o);
         4'd4:    w_byte = ASC_DOT;
         4'd5:    w_byte = digit_to_ascii(r_csec_t);
         4'd6:    w_byte = digit_to_ascii(r_csec_o);
         4'd7:    w_byte = ASC_CR;
         4'd8:    w_byte = ASC_LF;
         default: w_byte = 8'h00;
      endcase
`else
      case (r_idx)
         4'd0:    w_byte = digit_to_ascii(r_sec_t);
         4'd1:    w_byte = digit_to_ascii(r_sec_o);
         4'd2:    w_byte = ASC_DOT;
         4'd3:    w_byte = digit_to_ascii(r_csec_t);
         4'd4:    w_byte = digit_to_ascii(r_csec_o);
         4'd5:    w_byte = ASC_CR;
         4'd6:    w_byte = ASC_LF;
         default: w_byte = 8'h00;
      endcase
`endif
   end

   // tx_start/tx_data are registered so uart_tx sees glitch-free signals;
   // the strobe therefore appears in the cycle after SEND, which is also the
   // first WAIT_ACK cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx       <= 4'd0;
         r_ack_cnt   <= '0;
         r_sec_snap  <= 8'd0;
         r_csec_snap <= 7'd0;
         r_sec_t     <= 4'd0;
         r_sec_o     <= 4'd0;
         r_csec_t    <= 4'd0;
         r_csec_o    <= 4'd0;
         r_tx_data   <= 8'd0;
         r_tx_start  <= 1'b0;
         r_drop      <= 1'b0;
`ifdef STOPWATCH_UART_FMT_MIN_EN
         r_min_snap  <= 2'd0;
         r_min_d     <= 4'd0;
`endif
      end else begin
         r_drop     <= trig && (r_state != FMT_IDLE);
         r_tx_start <= (r_state == FMT_SEND);

         if (r_state == FMT_IDLE && trig) begin
            r_sec_snap  <= sec_bin;
            r_csec_snap <= csec_bin;
`ifdef STOPWATCH_UART_FMT_MIN_EN
            r_min_snap  <= min_bin;
`endif
         end

         if (r_state == FMT_LOAD) begin
            r_sec_t  <= (|w_sec_bcd[11:8])  ? 4'd9 : w_sec_bcd[7:4];
            r_sec_o  <= (|w_sec_bcd[11:8])  ? 4'd9 : w_sec_bcd[3:0];
            r_csec_t <= (|w_csec_bcd[11:8]) ? 4'd9 : w_csec_bcd[7:4];
            r_csec_o <= (|w_csec_bcd[11:8]) ? 4'd9 : w_csec_bcd[3:0];
`ifdef STOPWATCH_UART_FMT_MIN_EN
            r_min_d  <= {2'b00, r_min_snap};
`endif
         end

         if (r_state == FMT_SEND)
            r_tx_data <= w_byte;

         if (r_state == FMT_WAIT_ACK)
            r_ack_cnt <= r_ack_cnt + c_CNT_W'(1);
         else
            r_ack_cnt <= '0;

         if (r_state == FMT_IDLE)
            r_idx <= 4'd0;
         else if (r_state == FMT_NEXT && r_idx != c_LAST_IDX)
            r_idx <= r_idx + 4'd1;
      end
   end

   assign tx_data  = r_tx_data;
   assign tx_start = r_tx_start;
   assign busy     = (r_state != FMT_IDLE);
   assign drop     = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_uart_fmt.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_stopwatch_uart_fmt
// Purpose  : Self-checking bench for stopwatch_uart_fmt. A frame model turns
//            each accepted snapshot into its expected ASCII bytes; a monitor
//            compares every tx_start byte against it. Directed checks pin
//            latency, spacing, drop behaviour, reset and literal frames.
// Revision : 1.0 - initial release
//==============================================================================
module tb_stopwatch_uart_fmt;

`ifdef STOPWATCH_UART_FMT_MIN_EN
   localparam int FLEN = 9;
   localparam int OFF  = 2;
`else
   localparam int FLEN = 7;
   localparam int OFF  = 0;
`endif
   localparam int ACK_TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       trig;
   logic [7:0] sec_bin;
   logic [6:0] csec_bin;
   logic [1:0] min_bin;
   logic       tx_busy;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       busy;
   logic       drop;

   always #5 clk = ~clk;

   stopwatch_uart_fmt #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk      (clk),
      .rst      (rst),
      .trig     (trig),
      .sec_bin  (sec_bin),
      .csec_bin (csec_bin),
      .min_bin  (min_bin),
      .tx_busy  (tx_busy),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .busy     (busy),
      .drop     (drop)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // ---------------- frame model ----------------
   logic [7:0] exp_q[$];

   function automatic void push_frame(input int m, input int s, input int c);
      int sc, cc;
      sc = (s > 99) ? 99 : s;
      cc = (c > 99) ? 99 : c;
`ifdef STOPWATCH_UART_FMT_MIN_EN
      exp_q.push_back(8'(48 + m));
      exp_q.push_back(8'h3A);
`endif
      exp_q.push_back(8'(48 + sc / 10));
      exp_q.push_back(8'(48 + sc % 10));
      exp_q.push_back(8'h2E);
      exp_q.push_back(8'(48 + cc / 10));
      exp_q.push_back(8'(48 + cc % 10));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endfunction

   // ---------------- uart_tx model ----------------
   // mode 1: busy rises 2 cycles after the start strobe, holds 'hold' cycles.
   // mode 0: busy tied low.
   int uart_mode = 0;
   int hold      = 1;
   int u_d = 0;
   int u_h = 0;

   always @(posedge clk) begin
      if (rst || uart_mode == 0) begin
         tx_busy <= 1'b0;
         u_d     <= 0;
         u_h     <= 0;
      end else begin
         u_d <= (tx_start === 1'b1) ? 1 : 0;
         if (u_d == 1) begin
            tx_busy <= 1'b1;
            u_h     <= hold;
         end else if (u_h > 1) begin
            u_h <= u_h - 1;
         end else if (u_h == 1) begin
            u_h     <= 0;
            tx_busy <= 1'b0;
         end
      end
   end

   // ---------------- monitor ----------------
   int         starts[$];
   logic [7:0] got[$];
   int         drop_cnt  = 0;
   int         drop_cyc  = -1;
   int         last_fall = -1;
   int         busy_fall = -1;
   logic       prev_txb   = 1'b0;
   logic       prev_busy  = 1'b0;
   logic       prev_start = 1'b0;

   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         if (tx_start === 1'b1) begin
            starts.push_back(cyc);
            got.push_back(tx_data);
            if (exp_q.size() == 0)
               chk("unexpected_tx_start", exp_q.size(), 1);
            else
               chk("tx_data", tx_data, exp_q.pop_front());
            if (prev_start)
               chk("tx_start_width", prev_start, 1'b0);
         end
         if (drop === 1'b1) begin
            drop_cnt++;
            drop_cyc = cyc;
         end
         if (prev_txb && tx_busy === 1'b0)  last_fall = cyc;
         if (prev_busy && busy === 1'b0)    busy_fall = cyc;
         prev_start = (tx_start === 1'b1);
         prev_txb   = (tx_busy === 1'b1);
         prev_busy  = (busy === 1'b1);
      end else begin
         prev_start = 1'b0;
         prev_txb   = 1'b0;
         prev_busy  = 1'b0;
      end
   end

   // ---------------- helpers ----------------
   int t_trig;

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_rec();
      starts.delete();
      got.delete();
      last_fall = -1;
      busy_fall = -1;
   endtask

   task automatic send_trig(input bit accept);
      @(posedge clk);
      #1;
      trig   = 1'b1;
      t_trig = cyc;
      if (accept) push_frame(int'(min_bin), int'(sec_bin), int'(csec_bin));
      @(posedge clk);
      #1;
      trig = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      step();
      while (busy !== 1'b0 && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) chk({name, "_timeout"}, n, 0);
   endtask

   // s holds the 7-byte "SS.CC\r\n" tail, first byte in the top bits.
   task automatic check_lit(input string name, input logic [55:0] s);
      chk({name, "_count"}, got.size(), FLEN);
      if (got.size() == FLEN) begin
`ifdef STOPWATCH_UART_FMT_MIN_EN
         chk({name, "_min"}, got[0], 8'h32);
         chk({name, "_colon"}, got[1], 8'h3A);
`endif
         for (int i = 0; i < 7; i++)
            chk($sformatf("%s_byte%0d", name, i), got[OFF + i], s[55 - 8*i -: 8]);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int d0, n, f, n0;
      rst      = 1'b1;
      trig     = 1'b0;
      sec_bin  = 8'd0;
      csec_bin = 7'd0;
      min_bin  = 2'd2;

      repeat (3) @(posedge clk);
      step();
      chk("reset_busy", busy, 1'b0);
      chk("reset_tx_start", tx_start, 1'b0);
      chk("reset_tx_data", tx_data, 8'h00);
      chk("reset_drop", drop, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic frame 42.07, long uart busy.
      uart_mode = 1;
      hold      = 100;
      sec_bin   = 8'd42;
      csec_bin  = 7'd7;
      clear_rec();
      send_trig(1);
      step();
      chk("busy_after_trig", busy, 1'b1);
      wait_done("basic", 2000);
      check_lit("basic", 56'h34_32_2E_30_37_0D_0A);
      if (starts.size() > 0) chk("first_latency", starts[0] - t_trig, 3);
      chk("busy_after_last_fall", busy_fall - last_fall, 2);
      chk("model_drained", exp_q.size(), 0);

      // Clamp to 99.99.
      hold     = 3;
      sec_bin  = 8'd200;
      csec_bin = 7'd127;
      clear_rec();
      send_trig(1);
      wait_done("clamp", 500);
      check_lit("clamp", 56'h39_39_2E_39_39_0D_0A);

      // 00.00, then a trig in the cycle the FSM returns to IDLE.
      sec_bin  = 8'd0;
      csec_bin = 7'd0;
      clear_rec();
      send_trig(1);
      n = 0;
      step();
      while (!(starts.size() == FLEN && last_fall > starts[FLEN-1]) && n < 500) begin
         step();
         n++;
      end
      if (n >= 500) chk("zero_last_fall_timeout", n, 0);
      f  = cyc;
      d0 = drop_cnt;
      @(posedge clk);
      #1;
      trig = 1'b1;
      @(posedge clk);
      #1;
      trig = 1'b0;
      step();
      chk("drop_at_idle_return", drop_cnt - d0, 1);
      chk("drop_at_idle_return_cycle", drop_cyc - f, 2);
      repeat (20) step();
      check_lit("zero", 56'h30_30_2E_30_30_0D_0A);
      chk("idle_after_return_drop", busy, 1'b0);

      // Drop while busy; counters change after the snapshot.
      sec_bin  = 8'd13;
      csec_bin = 7'd58;
      clear_rec();
      d0 = drop_cnt;
      send_trig(1);
      sec_bin  = 8'd77;
      csec_bin = 7'd11;
      repeat (8) @(posedge clk);
      send_trig(0);
      n = t_trig;
      wait_done("drop", 500);
      chk("drop_count", drop_cnt - d0, 1);
      chk("drop_cycle", drop_cyc - n, 1);
      check_lit("drop", 56'h31_33_2E_35_38_0D_0A);

      // Timeout: tx_busy tied low.
      uart_mode = 0;
      sec_bin   = 8'd59;
      csec_bin  = 7'd99;
      clear_rec();
      send_trig(1);
      wait_done("timeout", FLEN * 25 + 20);
      check_lit("timeout", 56'h35_39_2E_39_39_0D_0A);
      if (starts.size() > 0) chk("timeout_latency", starts[0] - t_trig, 3);
      for (int i = 1; i < starts.size(); i++)
         chk($sformatf("timeout_spacing%0d", i), starts[i] - starts[i-1], ACK_TIMEOUT + 3);

      // Reset during byte 3's WAIT_DONE.
      uart_mode = 1;
      hold      = 20;
      sec_bin   = 8'd31;
      csec_bin  = 7'd4;
      clear_rec();
      send_trig(1);
      n = 0;
      while (starts.size() < 4 && n < 500) begin
         step();
         n++;
      end
      if (n >= 500) chk("reset_wait_timeout", n, 0);
      repeat (5) step();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      step();
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_tx_start", tx_start, 1'b0);
      chk("midrst_tx_data", tx_data, 8'h00);
      n0 = starts.size();
      repeat (10) step();
      chk("midrst_no_more_starts", starts.size() - n0, 0);

      sec_bin  = 8'd8;
      csec_bin = 7'd90;
      clear_rec();
      send_trig(1);
      wait_done("after_rst", 1000);
      check_lit("after_rst", 56'h30_38_2E_39_30_0D_0A);

`ifdef STOPWATCH_UART_FMT_MIN_EN
      // Minutes prefix: "2:05.50\r\n".
      hold     = 3;
      min_bin  = 2'd2;
      sec_bin  = 8'd5;
      csec_bin = 7'd50;
      clear_rec();
      send_trig(1);
      wait_done("minutes", 500);
      check_lit("minutes", 56'h30_35_2E_35_30_0D_0A);
`endif

      chk("final_model_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
